// File: rtl/cla_pipe_adder.sv
// Three-stage pipelined carry-lookahead adder/subtractor built from 4-bit groups
// with a second-level group lookahead, streaming through a valid/ready handshake.
module cla_pipe_adder #(
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned NGRP  = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             g_n,
    output logic             p_n
);

    if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_width_check
        $error("cla_pipe_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    // Flat sum-of-products lookahead across groups 0..top, seeded with a carry-in.
    function automatic logic lookahead(input logic [NGRP-1:0] gk, input logic [NGRP-1:0] pk,
                                       input logic seed, input int top);
        logic res;
        logic run;
        res = 1'b0;
        run = 1'b1;
        for (int j = int'(NGRP) - 1; j >= 0; j--) begin
            if (j <= top) begin
                res = res | (run & gk[j]);
                run = run & pk[j];
            end
        end
        return res | (run & seed);
    endfunction

    logic                 advance;
    logic [WIDTH-1:0]     bb;
    logic                 c0;

    logic                 v1;
    logic                 c0_1;
    logic [WIDTH-1:0]     g1, p1, h1;

    logic [NGRP-1:0]      grp_g, grp_p;
    logic [NGRP:0]        grp_c;
    logic                 word_g;

    logic                 v2;
    logic                 gw2, pw2;
    logic [NGRP:0]        c2;
    logic [NGRP-1:0][2:0] gl2, pl2;
    logic [WIDTH-1:0]     h2;
    logic [WIDTH-1:0]     bit_c;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    assign bb = sub ? ~b : b;
    assign c0 = sub ? ~cin : cin;

    // Per-group generate/propagate from registered bit terms.
    for (genvar k = 0; k < NGRP; k++) begin : g_grp_gp
        localparam int unsigned L = 4 * k;
        assign grp_g[k] = g1[L+3]
                        | (p1[L+3] & g1[L+2])
                        | (p1[L+3] & p1[L+2] & g1[L+1])
                        | (p1[L+3] & p1[L+2] & p1[L+1] & g1[L]);
        assign grp_p[k] = &p1[L +: 4];
    end

    assign grp_c[0] = c0_1;
    for (genvar k = 0; k < NGRP; k++) begin : g_grp_carry
        assign grp_c[k+1] = lookahead(grp_g, grp_p, c0_1, k);
    end
    assign word_g = lookahead(grp_g, grp_p, 1'b0, int'(NGRP) - 1);

    // Intra-group carries: 74182 equations seeded with the registered group carry.
    for (genvar k = 0; k < NGRP; k++) begin : g_bit_carry
        localparam int unsigned L = 4 * k;
        assign bit_c[L]   = c2[k];
        assign bit_c[L+1] = gl2[k][0] | (pl2[k][0] & c2[k]);
        assign bit_c[L+2] = gl2[k][1]
                          | (pl2[k][1] & gl2[k][0])
                          | (pl2[k][1] & pl2[k][0] & c2[k]);
        assign bit_c[L+3] = gl2[k][2]
                          | (pl2[k][2] & gl2[k][1])
                          | (pl2[k][2] & pl2[k][1] & gl2[k][0])
                          | (pl2[k][2] & pl2[k][1] & pl2[k][0] & c2[k]);
    end

    // Stage 1: conditioned operand bit terms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            c0_1 <= 1'b0;
            g1   <= '0;
            p1   <= '0;
            h1   <= '0;
        end else if (advance) begin
            v1 <= in_valid;
            if (in_valid) begin
                c0_1 <= c0;
                g1   <= a & bb;
                p1   <= a | bb;
                h1   <= a ^ bb;
            end
        end
    end

    // Stage 2: group carries and whole-word generate/propagate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2  <= 1'b0;
            gw2 <= 1'b0;
            pw2 <= 1'b0;
            c2  <= '0;
            gl2 <= '0;
            pl2 <= '0;
            h2  <= '0;
        end else if (advance) begin
            v2 <= v1;
            if (v1) begin
                gw2 <= word_g;
                pw2 <= &grp_p;
                c2  <= grp_c;
                h2  <= h1;
                for (int k = 0; k < int'(NGRP); k++) begin
                    gl2[k] <= g1[4*k +: 3];
                    pl2[k] <= p1[4*k +: 3];
                end
            end
        end
    end

    // Stage 3: result register, held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            g_n       <= 1'b1;
            p_n       <= 1'b1;
        end else if (advance) begin
            out_valid <= v2;
            if (v2) begin
                sum  <= h2 ^ bit_c;
                cout <= c2[NGRP];
                ovf  <= bit_c[WIDTH-1] ^ c2[NGRP];
                g_n  <= ~gw2;
                p_n  <= ~pw2;
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed and randomized bench for cla_pipe_adder: WIDTH 16/4/8/32 instances share one
// handshake; a scoreboard of model results is compared as each result is consumed.
module tb_cla_pipe_adder;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        g_n;
        logic        p_n;
    } res_t;

    typedef struct packed {
        res_t r16;
        res_t r4;
        res_t r8;
        res_t r32;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, cin, sub;
    logic [31:0] a, b;

    logic        in_ready, out_valid, cout, ovf, g_n, p_n;
    logic [15:0] sum;
    logic        in_ready4, out_valid4, cout4, ovf4, g_n4, p_n4;
    logic [3:0]  sum4;
    logic        in_ready8, out_valid8, cout8, ovf8, g_n8, p_n8;
    logic [7:0]  sum8;
    logic        in_ready32, out_valid32, cout32, ovf32, g_n32, p_n32;
    logic [31:0] sum32;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
        .ovf(ovf), .g_n(g_n), .p_n(p_n));

    cla_pipe_adder #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a[3:0]), .b(b[3:0]), .cin(cin), .sub(sub),
        .out_valid(out_valid4), .out_ready(out_ready), .sum(sum4), .cout(cout4),
        .ovf(ovf4), .g_n(g_n4), .p_n(p_n4));

    cla_pipe_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
        .out_valid(out_valid8), .out_ready(out_ready), .sum(sum8), .cout(cout8),
        .ovf(ovf8), .g_n(g_n8), .p_n(p_n8));

    cla_pipe_adder #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid32), .out_ready(out_ready), .sum(sum32), .cout(cout32),
        .ovf(ovf32), .g_n(g_n32), .p_n(p_n32));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide arithmetic, masked to the instance width.
    function automatic res_t model(input int unsigned w, input logic [31:0] av,
                                   input logic [31:0] bv, input logic ci, input logic s);
        res_t        r;
        logic [63:0] mask, aa, bb, full, gsum;
        logic        c0;
        mask   = (64'd1 << w) - 64'd1;
        aa     = {32'd0, av} & mask;
        bb     = (s ? ~{32'd0, bv} : {32'd0, bv}) & mask;
        c0     = s ^ ci;
        full   = aa + bb + {63'd0, c0};
        gsum   = aa + bb;
        r.sum  = 32'(full & mask);
        r.cout = full[w];
        r.ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
        r.g_n  = ~gsum[w];
        r.p_n  = ~((aa | bb) == mask);
        return r;
    endfunction

    function automatic exp_t mk_exp();
        exp_t e;
        e.r16 = model(16, a, b, cin, sub);
        e.r4  = model(4, a, b, cin, sub);
        e.r8  = model(8, a, b, cin, sub);
        e.r32 = model(32, a, b, cin, sub);
        return e;
    endfunction

    // Scoreboard: push on accept, pop and compare on each completed output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid_agree", 64'({out_valid4, out_valid8, out_valid32}), {61'd0, {3{out_valid}}});
            chk("ready_agree", 64'({in_ready4, in_ready8, in_ready32}), {61'd0, {3{in_ready}}});
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("res_w16", 64'({sum, cout, ovf, g_n, p_n}),
                        64'({e.r16.sum[15:0], e.r16.cout, e.r16.ovf, e.r16.g_n, e.r16.p_n}));
                    chk("res_w4", 64'({sum4, cout4, ovf4, g_n4, p_n4}),
                        64'({e.r4.sum[3:0], e.r4.cout, e.r4.ovf, e.r4.g_n, e.r4.p_n}));
                    chk("res_w8", 64'({sum8, cout8, ovf8, g_n8, p_n8}),
                        64'({e.r8.sum[7:0], e.r8.cout, e.r8.ovf, e.r8.g_n, e.r8.p_n}));
                    chk("res_w32", 64'({sum32, cout32, ovf32, g_n32, p_n32}),
                        64'({e.r32.sum, e.r32.cout, e.r32.ovf, e.r32.g_n, e.r32.p_n}));
                end
            end
            if (in_valid && in_ready) sb.push_back(mk_exp());
        end
    end

    task automatic push_beat(input logic [31:0] av, input logic [31:0] bv,
                             input logic ci, input logic s);
        logic acc;
        a = av; b = bv; cin = ci; sub = s; in_valid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("push_accepted", 64'(acc), 64'd1);
    endtask

    task automatic run_beat(input string tag, input logic [31:0] av, input logic [31:0] bv,
                            input logic ci, input logic s, input logic [15:0] es,
                            input logic ec, input logic eo, input logic eg, input logic ep);
        int   lat;
        logic seen;
        push_beat(av, bv, ci, s);
        lat  = 1;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else begin
                lat++;
                @(posedge clk); #1;
            end
        end
        chk({tag, "_lat"}, 64'(lat), 64'd3);
        chk({tag, "_sum"}, 64'(sum), 64'(es));
        chk({tag, "_flags"}, 64'({cout, ovf, g_n, p_n}), 64'({ec, eo, eg, ep}));
        @(posedge clk); #1;
    endtask

    initial begin
        int sent;
        int cyc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_outs", 64'({sum, cout, ovf, g_n, p_n}), 64'({16'h0, 1'b0, 1'b0, 1'b1, 1'b1}));
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_sum32", 64'(sum32), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_beat("t1", 32'h1234, 32'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b1);
        run_beat("t2a", 32'hFFFF, 32'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        run_beat("t2b", 32'hFFFF, 32'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        run_beat("t3a", 32'h7FFF, 32'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b1);
        run_beat("t3b", 32'h0005, 32'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b1);
        run_beat("t3c", 32'h8000, 32'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1);
        run_beat("t3d", 32'h0010, 32'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, 1'b0, 1'b1);

        // Back-to-back stream against a stalled sink, then release.
        out_ready = 1'b0;
        push_beat(32'd1, 32'd1, 1'b0, 1'b0);
        push_beat(32'd2, 32'd2, 1'b0, 1'b0);
        push_beat(32'd3, 32'd3, 1'b0, 1'b0);
        a = 32'd4; b = 32'd4; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", 64'(out_valid), 64'd1);
            chk("t4_hold_sum", 64'(sum), 64'h0002);
            chk("t4_hold_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_drain_valid", 64'(out_valid), 64'd1);
            chk("t4_drain_sum", 64'(sum), 64'(2 * (i + 1)));
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        @(negedge clk);
        chk("t4_empty_valid", 64'(out_valid), 64'd0);
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;

        // Asynchronous reset with beats in flight and a result held at the output.
        push_beat(32'hFFF0, 32'h001F, 1'b0, 1'b0);
        push_beat(32'h0033, 32'h0044, 1'b0, 1'b0);
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("t5_pre_valid", 64'(out_valid), 64'd1);
        chk("t5_pre_outs", 64'({sum, g_n, p_n}), 64'({16'h000F, 1'b0, 1'b0}));
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("t5_rst_valid", 64'(out_valid), 64'd0);
        chk("t5_rst_outs", 64'({sum, cout, ovf, g_n, p_n}), 64'({16'h0, 1'b0, 1'b0, 1'b1, 1'b1}));
        chk("t5_rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_no_stale", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end

        // Random stream with random bubbles and back-pressure across all widths.
        sent = 0;
        cyc  = 0;
        while (sent < 1000 && cyc < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom);
            sub = 1'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("t6_sent", 64'(sent), 64'd1000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 20 && sb.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("t6_drained", 64'(sb.size()), 64'd0);
        chk("t6_idle", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
